// File: rtl/i2c_pkg.sv
// Shared encodings for the N-byte I2C master: one-hot FSM states, quarter-phase
// indices and the effective byte-count helper.
package i2c_pkg;

    typedef enum logic [8:0] {
        StIdle    = 9'b000000001,
        StStart   = 9'b000000010,
        StAddr    = 9'b000000100,
        StAddrAck = 9'b000001000,
        StWdata   = 9'b000010000,
        StWack    = 9'b000100000,
        StRdata   = 9'b001000000,
        StMack    = 9'b010000000,
        StStop    = 9'b100000000
    } state_e;

    localparam logic [1:0] PhQ0 = 2'd0;
    localparam logic [1:0] PhQ1 = 2'd1;
    localparam logic [1:0] PhQ2 = 2'd2;
    localparam logic [1:0] PhQ3 = 2'd3;

    // Requested byte count clipped to what the payload registers can hold.
    function automatic logic [2:0] eff_count(input logic [2:0] nbytes, input int unsigned maxb);
        return (32'(nbytes) > maxb) ? 3'(maxb) : nbytes;
    endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator: tick_o pulses on the last CLK of each quarter,
// phase_o is the index of the quarter currently in progress.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       en_i,
    output logic       tick_o,
    output logic [1:0] phase_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      phase_q, phase_d;

    assign tick_o  = en_i && (cnt_q == CntMax);
    assign phase_o = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = PhQ0;
        end else if (tick_o) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q   <= '0;
            phase_q <= PhQ0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_master_nbyte.sv
// Single-master I2C controller moving up to MAXB data bytes per transaction,
// with all bus-facing and status outputs registered.
module i2c_master_nbyte
    import i2c_pkg::*;
#(
    parameter int unsigned MAXB    = 2,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START_STB,
    input  logic              RNW,
    input  logic [6:0]        I2C_ADDR,
    input  logic [2:0]        NBYTES,
    input  logic [8*MAXB-1:0] WR_DATA,
    input  logic              SDA_IN,
    output logic              SCL,
    output logic              SDA_OUT,
    output logic              SDA_OE,
    output logic [8*MAXB-1:0] RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              NACK_ERR
);

    localparam int unsigned W = 8 * MAXB;

    state_e         state_q, state_d;
    logic [2:0]     bit_q, bit_d;
    logic [2:0]     rem_q, rem_d;
    logic [7:0]     sh_q, sh_d;
    logic           rnw_q, rnw_d;
    logic           ack_q, ack_d;
    logic [W-1:0]   wr_q, wr_d;
    logic [W-1:0]   rd_q, rd_d;
    logic           scl_q, scl_d;
    logic           sda_q, sda_d;
    logic           oe_q, oe_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           nack_q, nack_d;

    logic           tick;
    logic [1:0]     phase;
    logic           bit_end, q2_start, q3_start;
    logic [2:0]     byte_idx;
    logic [7:0]     next_byte;

    i2c_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .CLK     (CLK),
        .RESET   (RESET),
        .en_i    (busy_q),
        .tick_o  (tick),
        .phase_o (phase)
    );

    // Events take effect on the edge that opens the named quarter.
    assign bit_end  = tick && (phase == PhQ3);
    assign q2_start = tick && (phase == PhQ1);
    assign q3_start = tick && (phase == PhQ2);

    // rem_q counts bytes not yet started, so the next byte sits at index rem_q-1.
    assign byte_idx = rem_q - 3'd1;

    always_comb begin
        next_byte = '0;
        for (int i = 0; i < int'(MAXB); i++) begin
            if (byte_idx == 3'(i)) next_byte = wr_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        rnw_d   = rnw_q;
        ack_d   = ack_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        oe_d    = oe_q;
        nack_d  = nack_q;
        done_d  = 1'b0;

        if (q2_start) scl_d = 1'b1;
        if (bit_end)  scl_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START_STB) begin
                    state_d = StStart;
                    rnw_d   = RNW;
                    wr_d    = WR_DATA;
                    rd_d    = '0;
                    nack_d  = 1'b0;
                    rem_d   = eff_count(NBYTES, MAXB);
                    sh_d    = {I2C_ADDR, RNW};
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (q2_start) sda_d = 1'b0;
                if (bit_end) begin
                    state_d = StAddr;
                    sda_d   = sh_q[7];
                    sh_d    = {sh_q[6:0], 1'b0};
                end
            end
            StAddr, StWdata: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = (state_q == StAddr) ? StAddrAck : StWack;
                        oe_d    = 1'b0;
                        bit_d   = '0;
                        if (state_q == StWdata) rem_d = rem_q - 3'd1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sda_d = sh_q[7];
                        sh_d  = {sh_q[6:0], 1'b0};
                    end
                end
            end
            StAddrAck, StWack: begin
                if (q2_start) ack_d = SDA_IN;
                if (bit_end) begin
                    if (ack_q || rem_q == '0) begin
                        if (ack_q) nack_d = 1'b1;
                        state_d = StStop;
                        oe_d    = 1'b1;
                        sda_d   = 1'b0;
                    end else if (rnw_q) begin
                        state_d = StRdata;
                    end else begin
                        state_d = StWdata;
                        oe_d    = 1'b1;
                        sda_d   = next_byte[7];
                        sh_d    = {next_byte[6:0], 1'b0};
                    end
                end
            end
            StRdata: begin
                if (q2_start) rd_d = {rd_q[W-2:0], SDA_IN};
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = StMack;
                        oe_d    = 1'b1;
                        bit_d   = '0;
                        rem_d   = rem_q - 3'd1;
                        // NACK the final byte so the slave releases SDA for STOP.
                        sda_d   = (rem_q == 3'd1);
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StMack: begin
                if (bit_end) begin
                    if (rem_q != '0) begin
                        state_d = StRdata;
                        oe_d    = 1'b0;
                    end else begin
                        state_d = StStop;
                        sda_d   = 1'b0;
                    end
                end
            end
            StStop: begin
                if (q3_start) sda_d = 1'b1;
                if (bit_end) begin
                    state_d = StIdle;
                    scl_d   = 1'b1;
                    sda_d   = 1'b1;
                    oe_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StIdle;
            bit_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            rnw_q   <= 1'b0;
            ack_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            oe_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            rnw_q   <= rnw_d;
            ack_q   <= ack_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nack_q  <= nack_d;
        end
    end

    assign SCL      = scl_q;
    assign SDA_OUT  = sda_q;
    assign SDA_OE   = oe_q;
    assign RD_DATA  = rd_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign NACK_ERR = nack_q;

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Directed bench for i2c_master_nbyte with a bus-level slave model; bytes seen on
// the wire are queued by the monitor and compared against expected queues.
module tb_i2c_master_nbyte;

    localparam int unsigned MAXB    = 2;
    localparam int unsigned CLK_DIV = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START_STB = 1'b0;
    logic        RNW = 1'b0;
    logic [6:0]  I2C_ADDR = '0;
    logic [2:0]  NBYTES = '0;
    logic [15:0] WR_DATA = '0;
    logic        SDA_IN;
    logic        SCL, SDA_OUT, SDA_OE, BUSY, DONE, NACK_ERR;
    logic [15:0] RD_DATA;

    logic        slave_sda = 1'b1;
    assign SDA_IN = (SDA_OE ? SDA_OUT : 1'b1) & slave_sda;

    i2c_master_nbyte #(
        .MAXB    (MAXB),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START_STB (START_STB),
        .RNW       (RNW),
        .I2C_ADDR  (I2C_ADDR),
        .NBYTES    (NBYTES),
        .WR_DATA   (WR_DATA),
        .SDA_IN    (SDA_IN),
        .SCL       (SCL),
        .SDA_OUT   (SDA_OUT),
        .SDA_OE    (SDA_OE),
        .RD_DATA   (RD_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .NACK_ERR  (NACK_ERR)
    );

    always #5 CLK = ~CLK;

    // Slave model configuration and observation queues
    logic       addr_nack_cfg = 1'b0;
    int         rd_cnt_cfg = 0;
    logic [7:0] rd_bytes [4];
    logic [7:0] obs_byte_q [$];
    logic       obs_ack_q [$];
    logic [7:0] exp_byte_q [$];
    logic       exp_ack_q [$];

    logic       prev_scl = 1'b1, prev_sda = 1'b1, in_xfer = 1'b0, is_read = 1'b0;
    int         frame = 0, pos = 0;
    logic [7:0] shreg = '0;

    always @(negedge CLK) begin
        if (!RESET) begin
            in_xfer   = 1'b0;
            slave_sda = 1'b1;
        end else if (prev_scl && SCL && prev_sda && !SDA_IN) begin
            in_xfer = 1'b1;
            frame   = 0;
            pos     = 0;
            is_read = 1'b0;
        end else if (prev_scl && SCL && !prev_sda && SDA_IN) begin
            in_xfer   = 1'b0;
            slave_sda = 1'b1;
        end else if (in_xfer && !prev_scl && SCL) begin
            if (pos < 8) begin
                shreg = {shreg[6:0], SDA_IN};
                pos++;
                if (pos == 8 && (frame == 0 || !is_read)) obs_byte_q.push_back(shreg);
                if (pos == 8 && frame == 0) is_read = shreg[0];
            end else begin
                if (frame > 0 && is_read) obs_ack_q.push_back(SDA_IN);
                pos = 0;
                frame++;
            end
        end else if (in_xfer && prev_scl && !SCL) begin
            slave_sda = 1'b1;
            if (pos == 8) begin
                if (frame == 0)   slave_sda = addr_nack_cfg;
                else if (!is_read) slave_sda = 1'b0;
            end else if (is_read && frame > 0 && frame - 1 < rd_cnt_cfg) begin
                slave_sda = rd_bytes[frame-1][7-pos];
            end
        end
        prev_scl = SCL;
        prev_sda = SDA_IN;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic rnw, input logic [6:0] addr,
                           input logic [2:0] nb, input logic [15:0] wr, input int exp_cycles,
                           input logic exp_nack, input logic mid_stb);
        int         cyc;
        logic [7:0] ob;
        logic       oa;
        obs_byte_q.delete();
        obs_ack_q.delete();
        @(negedge CLK);
        RNW = rnw; I2C_ADDR = addr; NBYTES = nb; WR_DATA = wr; START_STB = 1'b1;
        @(posedge CLK); #1;
        START_STB = 1'b0;
        chk({tag, " busy"}, BUSY, 1);
        chk({tag, " nack_clr"}, NACK_ERR, 0);
        cyc = 0;
        while (!DONE && cyc < 2000) begin
            @(posedge CLK); #1;
            cyc++;
            if (mid_stb && cyc == 40) begin
                START_STB = 1'b1; RNW = ~rnw; I2C_ADDR = 7'h7F; NBYTES = 3'd1; WR_DATA = 16'hFFFF;
            end else begin
                START_STB = 1'b0;
            end
        end
        chk({tag, " cycles"}, cyc, exp_cycles);
        chk({tag, " done"}, DONE, 1);
        chk({tag, " nack"}, NACK_ERR, exp_nack);
        chk({tag, " nbytes"}, obs_byte_q.size(), exp_byte_q.size());
        while (exp_byte_q.size() > 0) begin
            ob = (obs_byte_q.size() > 0) ? obs_byte_q.pop_front() : 8'hxx;
            chk({tag, " byte"}, ob, exp_byte_q.pop_front());
        end
        chk({tag, " nacks"}, obs_ack_q.size(), exp_ack_q.size());
        while (exp_ack_q.size() > 0) begin
            oa = (obs_ack_q.size() > 0) ? obs_ack_q.pop_front() : 1'bx;
            chk({tag, " mack"}, oa, exp_ack_q.pop_front());
        end
        @(posedge CLK); #1;
        chk({tag, " done_pulse"}, DONE, 0);
        chk({tag, " idle"}, BUSY, 0);
    endtask

    initial begin
        int   n;
        logic reached;
        rd_bytes[0] = 8'h3C; rd_bytes[1] = 8'hC3; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h00;

        // Reset with a strobe held: must come up idle and ignore the strobe
        START_STB = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst scl", SCL, 1);
        chk("rst sda", SDA_OUT, 1);
        chk("rst oe", SDA_OE, 1);
        chk("rst busy", BUSY, 0);
        chk("rst done", DONE, 0);
        chk("rst nack", NACK_ERR, 0);
        chk("rst rd", RD_DATA, 0);
        @(negedge CLK);
        RESET = 1'b1; START_STB = 1'b0;
        @(posedge CLK); #1;
        chk("rst strobe dropped", BUSY, 0);

        // Two-byte write
        exp_byte_q = '{8'hA0, 8'hA5, 8'h5A};
        run_txn("wr2", 1'b0, 7'h50, 3'd2, 16'hA55A, 232, 1'b0, 1'b0);

        // Two-byte read: master ACKs first byte, NACKs last
        rd_cnt_cfg = 2;
        exp_byte_q = '{8'hA3};
        exp_ack_q  = '{1'b0, 1'b1};
        run_txn("rd2", 1'b1, 7'h51, 3'd2, 16'h0000, 232, 1'b0, 1'b0);
        chk("rd2 data", RD_DATA, 16'h3CC3);

        // Address-only probe (read direction) clears RD_DATA
        rd_cnt_cfg = 0;
        exp_byte_q = '{8'hA3};
        run_txn("probe", 1'b1, 7'h51, 3'd0, 16'h0000, 88, 1'b0, 1'b0);
        chk("probe rd", RD_DATA, 16'h0000);

        // Address NACK
        addr_nack_cfg = 1'b1;
        exp_byte_q = '{8'h44};
        run_txn("anack", 1'b0, 7'h22, 3'd1, 16'h00FF, 88, 1'b1, 1'b0);
        addr_nack_cfg = 1'b0;

        // Oversized count plus a strobe while busy
        exp_byte_q = '{8'h74, 8'h12, 8'h34};
        run_txn("clip", 1'b0, 7'h3A, 3'd7, 16'h1234, 232, 1'b0, 1'b1);

        // Reset during the second data byte
        @(negedge CLK);
        RNW = 1'b0; I2C_ADDR = 7'h50; NBYTES = 3'd2; WR_DATA = 16'hBEEF; START_STB = 1'b1;
        @(negedge CLK);
        START_STB = 1'b0;
        n = 0;
        reached = 1'b0;
        while (!reached && n < 1000) begin
            @(negedge CLK);
            n++;
            reached = (frame == 2 && pos >= 2);
        end
        chk("abort reach", reached, 1);
        RESET = 1'b0; START_STB = 1'b1;
        @(posedge CLK); #1;
        chk("abort scl", SCL, 1);
        chk("abort sda", SDA_OUT, 1);
        chk("abort oe", SDA_OE, 1);
        chk("abort busy", BUSY, 0);
        chk("abort done", DONE, 0);
        @(negedge CLK);
        RESET = 1'b1; START_STB = 1'b0;
        @(posedge CLK); #1;
        chk("abort strobe dropped", BUSY, 0);

        exp_byte_q = '{8'hA0, 8'hC6, 8'h3D};
        run_txn("after", 1'b0, 7'h50, 3'd2, 16'hC63D, 232, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
